// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like two-master arbiter: master IDs,
// transfer size encodings and the grant/lock state types.
package sram_like_arbiter_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered transactions.
// With SRAM_ARB_FLUSH_EN each entry also carries a cancel bit.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef SRAM_ARB_FLUSH_EN
    input  logic flush_inst,
    output logic head_cancel,
`endif
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_id
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      count;
    logic [DEPTH-1:0] ids;
    logic             do_push, do_pop;

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = ids[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ids    <= '0;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SRAM_ARB_FLUSH_EN
    logic [DEPTH-1:0] cancels;

    assign head_cancel = cancels[rd_ptr];

    // Stale slots may get marked too; a push always rewrites its cancel bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancels <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
                if (flush_inst && ids[i] == ID_INST)
                    cancels[i] <= 1'b1;
            if (do_push)
                cancels[wr_ptr] <= flush_inst & (push_id == ID_INST);
        end
    end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like bus arbiter with an in-order
// response ID FIFO. Optional flush-cancel of inst responses: SRAM_ARB_FLUSH_EN.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OUTS = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SRAM_ARB_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata
);

    lock_t  lock_q, lock_d;
    grant_t held_q, held_d, grant;
    logic   full, empty, head_id, push, deliver, inst_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= LK_FREE;
            held_q <= GRANT_INST;
        end else begin
            lock_q <= lock_d;
            held_q <= held_d;
        end
    end

    always_comb begin
        grant = data_req ? GRANT_DATA : GRANT_INST;
        if (lock_q == LK_HELD)
            grant = held_q;

        if (grant == GRANT_DATA) begin
            out_req   = data_req;
            out_wr    = data_wr;
            out_size  = data_size;
            out_addr  = data_addr;
            out_wdata = data_wdata;
        end else begin
            out_req   = inst_req;
            out_wr    = inst_wr;
            out_size  = inst_size;
            out_addr  = inst_addr;
            out_wdata = inst_wdata;
        end
        out_req = out_req & ~full & ~reset;

        // Hold the grant while a presented request waits for its accept.
        lock_d = (out_req && !out_addr_ok) ? LK_HELD : LK_FREE;
        held_d = grant;
    end

    assign push         = out_req & out_addr_ok;
    assign inst_addr_ok = push & (grant == GRANT_INST);
    assign data_addr_ok = push & (grant == GRANT_DATA);
    assign deliver      = out_data_ok & ~empty & ~reset;

`ifdef SRAM_ARB_FLUSH_EN
    logic head_cancel;

    arb_id_fifo #(.DEPTH(OUTS)) u_id_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_inst (flush),
        .head_cancel(head_cancel),
        .push       (push),
        .push_id    (grant),
        .pop        (deliver),
        .full       (full),
        .empty      (empty),
        .head_id    (head_id)
    );

    assign inst_resp = deliver & (head_id == ID_INST) & ~head_cancel;
`else
    arb_id_fifo #(.DEPTH(OUTS)) u_id_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_id    (grant),
        .pop        (deliver),
        .full       (full),
        .empty      (empty),
        .head_id    (head_id)
    );

    assign inst_resp = deliver & (head_id == ID_INST);
`endif

    assign inst_data_ok = inst_resp;
    assign data_data_ok = deliver & (head_id == ID_DATA);
    assign inst_rdata   = inst_data_ok ? out_rdata : '0;
    assign data_rdata   = data_data_ok ? out_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed vector bench for sram_like_arbiter (OUTS=2); the flush sequence
// runs only when SRAM_ARB_FLUSH_EN is defined.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd2;
    logic [31:0] inst_addr = 32'h1000, inst_wdata = 32'hAAAA_0000;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b1;
    logic [1:0]  data_size = 2'd1;
    logic [31:0] data_addr = 32'h2000, data_wdata = 32'hDDDD_0000;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        out_req, out_wr;
    logic [1:0]  out_size;
    logic [31:0] out_addr, out_wdata;
    logic        out_addr_ok = 1'b0, out_data_ok = 1'b0;
    logic [31:0] out_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTS(2)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SRAM_ARB_FLUSH_EN
        .flush       (flush),
`endif
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .out_req     (out_req),
        .out_wr      (out_wr),
        .out_size    (out_size),
        .out_addr    (out_addr),
        .out_wdata   (out_wdata),
        .out_addr_ok (out_addr_ok),
        .out_data_ok (out_data_ok),
        .out_rdata   (out_rdata)
    );

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rd;
        logic        oreq;
        logic [31:0] oaddr;
        logic        iaok, daok, idok, ddok;
        logic [31:0] ird, drd;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic ir, logic dr, logic aok, logic dok, logic [31:0] rd,
                                logic oreq, logic [31:0] oaddr, logic iaok, logic daok,
                                logic idok, logic ddok, logic [31:0] ird, logic [31:0] drd);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.oreq = oreq; v.oaddr = oaddr; v.iaok = iaok; v.daok = daok;
        v.idok = idok; v.ddok = ddok; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok,
                         input logic dok, input logic [31:0] rd);
        inst_req = ir; data_req = dr; out_addr_ok = aok; out_data_ok = dok; out_rdata = rd;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic is_data;
        is_data = (v.oaddr == 32'h2000);
        check({tag, " out_req"},      32'(out_req),      32'(v.oreq));
        check({tag, " out_addr"},     out_addr,          v.oaddr);
        check({tag, " out_wr"},       32'(out_wr),       32'(is_data));
        check({tag, " out_size"},     32'(out_size),     is_data ? 32'd1 : 32'd2);
        check({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(v.iaok));
        check({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'(v.daok));
        check({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'(v.idok));
        check({tag, " data_data_ok"}, 32'(data_data_ok), 32'(v.ddok));
        check({tag, " inst_rdata"},   inst_rdata,        v.ird);
        check({tag, " data_rdata"},   data_rdata,        v.drd);
    endtask

    // Apply inputs at the falling edge and compare 2 ns later, before the rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v.ir, v.dr, v.aok, v.dok, v.rd);
        #2;
        check_vec(tag, v);
    endtask

    initial begin
        //            ir dr aok dok rd            oreq addr          iaok daok idok ddok ird           drd
        tbl[0]  = mk(1, 1, 1, 0, 32'h0,    1, 32'h2000, 0, 1, 0, 0, 32'h0,    32'h0);    // both: data wins
        tbl[1]  = mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0,    32'h0);    // inst next, fifo full
        tbl[2]  = mk(1, 0, 1, 0, 32'h0,    0, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);    // blocked when full
        tbl[3]  = mk(1, 0, 1, 1, 32'h2222, 0, 32'h1000, 0, 0, 0, 1, 32'h0,    32'h2222); // pop when full, no bypass
        tbl[4]  = mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0,    32'h0);    // reasserts next cycle
        tbl[5]  = mk(0, 0, 0, 1, 32'h1111, 0, 32'h1000, 0, 0, 1, 0, 32'h1111, 32'h0);
        tbl[6]  = mk(0, 0, 0, 1, 32'h3333, 0, 32'h1000, 0, 0, 1, 0, 32'h3333, 32'h0);
        tbl[7]  = mk(0, 0, 0, 1, 32'h4444, 0, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);    // empty: ignored
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,    1, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);    // inst waits, locks
        tbl[9]  = mk(1, 1, 0, 0, 32'h0,    1, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);
        tbl[10] = mk(1, 1, 0, 0, 32'h0,    1, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);
        tbl[11] = mk(1, 1, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0,    32'h0);    // locked inst accepted
        tbl[12] = mk(0, 1, 1, 0, 32'h0,    1, 32'h2000, 0, 1, 0, 0, 32'h0,    32'h0);
        tbl[13] = mk(0, 0, 0, 1, 32'h1111, 0, 32'h1000, 0, 0, 1, 0, 32'h1111, 32'h0);    // in order: inst first
        tbl[14] = mk(0, 0, 0, 1, 32'h2222, 0, 32'h1000, 0, 0, 0, 1, 32'h0,    32'h2222);
        tbl[15] = mk(0, 1, 1, 0, 32'h0,    1, 32'h2000, 0, 1, 0, 0, 32'h0,    32'h0);
        tbl[16] = mk(1, 0, 1, 1, 32'h5555, 1, 32'h1000, 1, 0, 0, 1, 32'h0,    32'h5555); // push+pop, count stays 1
        tbl[17] = mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0,    32'h0);
        tbl[18] = mk(1, 0, 1, 0, 32'h0,    0, 32'h1000, 0, 0, 0, 0, 32'h0,    32'h0);
        tbl[19] = mk(0, 0, 0, 1, 32'h6666, 0, 32'h1000, 0, 0, 1, 0, 32'h6666, 32'h0);
        tbl[20] = mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0,    32'h0);    // two outstanding

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_vec("reset", mk(0, 0, 0, 0, 32'h0, 0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));

        for (int i = 0; i < 21; i++)
            step($sformatf("v%0d", i), tbl[i]);

        // Reset with two outstanding; a late response must be dropped.
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step("rst_late", mk(0, 0, 0, 1, 32'h9999, 0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));
        step("rst_acc0", mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0, 32'h0));
        step("rst_acc1", mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0, 32'h0));
        step("rst_full", mk(1, 0, 1, 0, 32'h0,    0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));
        step("rst_pop0", mk(0, 0, 0, 1, 32'h0A0A, 0, 32'h1000, 0, 0, 1, 0, 32'h0A0A, 32'h0));
        step("rst_pop1", mk(0, 0, 0, 1, 32'h0B0B, 0, 32'h1000, 0, 0, 1, 0, 32'h0B0B, 32'h0));

`ifdef SRAM_ARB_FLUSH_EN
        step("fl_acc",   mk(1, 0, 1, 0, 32'h0,    1, 32'h1000, 1, 0, 0, 0, 32'h0, 32'h0));
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(0, 0, 0, 1, 32'h7777);
        #2;
        check_vec("fl_drop", mk(0, 0, 0, 1, 32'h7777, 0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0);
        flush = 1'b1;
        #2;
        check_vec("fl_same", mk(1, 0, 1, 0, 32'h0, 1, 32'h1000, 1, 0, 0, 0, 32'h0, 32'h0));
        @(negedge clk);
        flush = 1'b0;
        drive(0, 1, 1, 0, 32'h0);
        #2;
        check_vec("fl_dacc", mk(0, 1, 1, 0, 32'h0, 1, 32'h2000, 0, 1, 0, 0, 32'h0, 32'h0));
        step("fl_drop2", mk(0, 0, 0, 1, 32'hABCD, 0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));
        step("fl_data",  mk(0, 0, 0, 1, 32'h8888, 0, 32'h1000, 0, 0, 0, 1, 32'h0, 32'h8888));
        step("fl_empty", mk(0, 0, 0, 1, 32'h4321, 0, 32'h1000, 0, 0, 0, 0, 32'h0, 32'h0));
`endif

        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter OUTS, default 2, meaning maximum outstanding accepted-but-unanswered transactions (power of 2, 2..8).
REQ-002 SHALL have ports: clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have inst master ports: inst_req in 1; inst_wr in 1; inst_size in 2; inst_addr in 32; inst_wdata in 32; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-004 SHALL have data master ports: data_req in 1; data_wr in 1; data_size in 2; data_addr in 32; data_wdata in 32; data_addr_ok out 1; data_data_ok out 1; data_rdata out 32.
REQ-005 SHALL have slave ports: out_req out 1; out_wr out 1; out_size out 2; out_addr out 32; out_wdata out 32; out_addr_ok in 1; out_data_ok in 1; out_rdata in 32.
REQ-006 SHALL have flush  input  1  pipeline flush from writeback exception/eret (present only with SRAM_ARB_FLUSH_EN).

Function
REQ-007 Grant: when the arbiter is unlocked and both masters request, SHALL grant data; a single requester SHALL be granted alone.
REQ-008 Lock: once out_req is asserted without out_addr_ok, grant SHALL be held on that master until the address handshake completes.
REQ-009 out_req/out_wr/out_size/out_addr/out_wdata SHALL combinationally mirror the granted master; out_req SHALL be 0 when the ID FIFO is full.
REQ-010 Granted master addr_ok SHALL equal out_addr_ok & out_req; the other master addr_ok SHALL be 0.
REQ-011 Each address handshake SHALL push the master ID (0 inst, 1 data) into an in-order FIFO of depth OUTS.
REQ-012 out_data_ok SHALL pop the FIFO head and SHALL be routed combinationally (zero latency) to that master data_ok with out_rdata on its rdata.
REQ-013 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo OUTS.
REQ-014 out_data_ok with an empty FIFO SHALL be ignored: no pop, no data_ok asserted.
REQ-015 A pop when full SHALL NOT permit a same-cycle push (no bypass); out_req reasserts the following cycle.
REQ-016 rdata of the non-selected master SHALL be 0.

Reset
REQ-017 On reset: FIFO empty, pointers 0, lock cleared, all cancel bits 0; out_req, inst/data addr_ok, inst/data data_ok SHALL be 0 the cycle after reset is sampled.
REQ-018 Reset mid-transaction SHALL discard all outstanding entries; late out_data_ok is handled per REQ-014.

Configuration
REQ-019 Macro SRAM_ARB_FLUSH_EN: when defined, flush SHALL set a cancel bit on every valid inst FIFO entry, including an inst entry pushed in the same cycle.
REQ-020 With SRAM_ARB_FLUSH_EN, popping a cancelled entry SHALL consume out_data_ok without asserting inst_data_ok; data entries are never cancelled.
REQ-021 With SRAM_ARB_FLUSH_EN, flush SHALL NOT withdraw a locked, presented request; it completes and is cancelled.
REQ-022 Without SRAM_ARB_FLUSH_EN, the flush port and cancel bits SHALL not exist and all responses SHALL be delivered.

Structure
REQ-023 Shared package SHALL hold master ID constants (ID_INST=0, ID_DATA=1) and size encodings (0 byte, 1 half, 2 word).
REQ-024 The ID FIFO SHALL be a sub-module arb_id_fifo (parameter depth, width 1 ID plus 1 cancel bit, flush-marks-all-inst port).

Verification
REQ-025 Both request at cycle 0 with out_addr_ok=1: data granted, data_addr_ok=1, inst_addr_ok=0; inst granted cycle 1.
REQ-026 Inst presented, out_addr_ok low 3 cycles, data_req rises cycle 1: out_addr stays inst_addr until accept at cycle 3.
REQ-027 OUTS=2, two accepts without response: out_req=0 on third request; one out_data_ok frees a slot, out_req=1 the next cycle.
REQ-028 Accept inst then data; out_data_ok with rdata 0x1111 then 0x2222: inst_rdata=0x1111, then data_rdata=0x2222, in order.
REQ-029 SRAM_ARB_FLUSH_EN: accept inst, pulse flush, out_data_ok: inst_data_ok stays 0, FIFO empties; next data response routes to data.
REQ-030 Reset with 2 outstanding, then out_data_ok: no data_ok asserted, count remains 0.
